// File: rtl/sum_chunk_feeder_if.sv
// sum_chunk_feeder_if: chunk handshake from upstream plus the drive bundle to the serial adder.
//   in_valid/in_a/in_b/in_ready   : upstream operand chunk handshake (LSB chunk first)
//   abort                         : synchronous abort of the running operation
//   add_rst/add_a/add_b           : drive the serial adder's reset and operands
//   chunk_valid/chunk_idx/chunk_last : tag the adder cycle that carries a real chunk
//   busy                          : feeder is not idle
//   master modport is the feeder; slave modport is the surrounding logic.
interface sum_chunk_feeder_if #(
    parameter int N  = 1024,
    parameter int CC = 32
);
    localparam int W  = N / CC;
    localparam int IW = $clog2(CC);
    logic          in_valid;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_ready;
    logic          abort;
    logic          add_rst;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          chunk_valid;
    logic [IW-1:0] chunk_idx;
    logic          chunk_last;
    logic          busy;
    modport master (
        input  in_valid, in_a, in_b, abort,
        output in_ready, add_rst, add_a, add_b, chunk_valid, chunk_idx, chunk_last, busy
    );
    modport slave (
        output in_valid, in_a, in_b, abort,
        input  in_ready, add_rst, add_a, add_b, chunk_valid, chunk_idx, chunk_last, busy
    );
endinterface

// File: rtl/sum_chunk_feeder.sv
// sum_chunk_feeder: feeds operand chunks LSB-first into a non-stallable chunked serial adder.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : sum_chunk_feeder_if.master (chunk handshake in, adder drive and chunk tags out)
//   When no chunk is available in RUN a bubble (a = all ones, b = 0) is presented; its carry-out
//   equals its carry-in, so the adder carry passes through untouched.
//   add_rst is held high in IDLE and CLEAR so the adder carry is 0 for every chunk 0.
module sum_chunk_feeder #(
    parameter int N  = 1024,
    parameter int CC = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sum_chunk_feeder_if.master    bus
);
    localparam int W  = N / CC;
    localparam int IW = $clog2(CC);
    localparam logic [IW:0]   CNT_MAX  = (IW + 1)'(CC);
    localparam logic [IW:0]   LAST_IDX = (IW + 1)'(CC - 1);

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t        state_q, state_d;
    logic          add_rst_q, add_rst_d;
    logic [W-1:0]  add_a_q, add_a_d;
    logic [W-1:0]  add_b_q, add_b_d;
    logic          chunk_valid_q, chunk_valid_d;
    logic [IW-1:0] chunk_idx_q, chunk_idx_d;
    logic          chunk_last_q, chunk_last_d;
    logic [IW:0]   acc_cnt_q, acc_cnt_d;
    logic [IW:0]   pres_cnt_q, pres_cnt_d;
    logic          xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            add_rst_q     <= 1'b1;
            add_a_q       <= '0;
            add_b_q       <= '0;
            chunk_valid_q <= 1'b0;
            chunk_idx_q   <= '0;
            chunk_last_q  <= 1'b0;
            acc_cnt_q     <= '0;
            pres_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            add_rst_q     <= add_rst_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            chunk_valid_q <= chunk_valid_d;
            chunk_idx_q   <= chunk_idx_d;
            chunk_last_q  <= chunk_last_d;
            acc_cnt_q     <= acc_cnt_d;
            pres_cnt_q    <= pres_cnt_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) ||
                        (state_q == RUN && !bus.abort && acc_cnt_q < CNT_MAX);
        xfer          = bus.in_valid && bus.in_ready;
        state_d       = state_q;
        add_rst_d     = add_rst_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        chunk_valid_d = chunk_valid_q;
        chunk_idx_d   = chunk_idx_q;
        chunk_last_d  = chunk_last_q;
        acc_cnt_d     = acc_cnt_q;
        pres_cnt_d    = pres_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d       = RUN;
                    add_rst_d     = 1'b0;
                    add_a_d       = bus.in_a;
                    add_b_d       = bus.in_b;
                    chunk_valid_d = 1'b1;
                    chunk_idx_d   = '0;
                    chunk_last_d  = 1'b0;
                    acc_cnt_d     = (IW + 1)'(1);
                    pres_cnt_d    = (IW + 1)'(1);
                end
            end
            RUN: begin
                if (bus.abort || chunk_last_q) begin
                    state_d       = CLEAR;
                    add_rst_d     = 1'b1;
                    add_a_d       = '1;
                    add_b_d       = '0;
                    chunk_valid_d = 1'b0;
                    chunk_last_d  = 1'b0;
                end else if (xfer) begin
                    add_a_d       = bus.in_a;
                    add_b_d       = bus.in_b;
                    chunk_valid_d = 1'b1;
                    chunk_idx_d   = pres_cnt_q[IW-1:0];
                    chunk_last_d  = pres_cnt_q == LAST_IDX;
                    acc_cnt_d     = acc_cnt_q + 1'b1;
                    pres_cnt_d    = pres_cnt_q + 1'b1;
                end else begin
                    // bubble: carry-out equals carry-in, so the adder carry is preserved
                    add_a_d       = '1;
                    add_b_d       = '0;
                    chunk_valid_d = 1'b0;
                    chunk_last_d  = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                add_rst_d     = 1'b1;
                chunk_valid_d = 1'b0;
                chunk_last_d  = 1'b0;
                acc_cnt_d     = '0;
                pres_cnt_d    = '0;
            end
        endcase
    end

    assign bus.add_rst     = add_rst_q;
    assign bus.add_a       = add_a_q;
    assign bus.add_b       = add_b_q;
    assign bus.chunk_valid = chunk_valid_q;
    assign bus.chunk_idx   = chunk_idx_q;
    assign bus.chunk_last  = chunk_last_q;
    assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_sum_chunk_feeder.sv
// tb_sum_chunk_feeder: directed bench for sum_chunk_feeder with a reference serial adder model.
module tb_sum_chunk_feeder;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic carry;
    logic [W:0] sum;

    sum_chunk_feeder_if #(.N(1024), .CC(32)) bus ();
    sum_chunk_feeder #(.N(1024), .CC(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // downstream serial adder: c = a + b + carry, carry cleared while add_rst is high
    assign sum = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, carry};
    always @(posedge clk or posedge bus.add_rst)
        if (bus.add_rst) carry <= 1'b0;
        else carry <= sum[W];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && bus.busy; k++) step();
        chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.abort = 1'b0;
        drive(1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_add_rst", 64'(bus.add_rst), 64'd1);
        chk("rst_add_a", 64'(bus.add_a), 64'd0);
        chk("rst_add_b", 64'(bus.add_b), 64'd0);
        chk("rst_cv", 64'(bus.chunk_valid), 64'd0);
        chk("rst_idx", 64'(bus.chunk_idx), 64'd0);
        chk("rst_last", 64'(bus.chunk_last), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        step();

        // back-to-back chunks a = i, b = 1
        drive(1'b1, 32'd0, 32'd1);
        for (int i = 0; i < 32; i++) begin
            step();
            chk("b2b_cv", 64'(bus.chunk_valid), 64'd1);
            chk("b2b_idx", 64'(bus.chunk_idx), 64'(i));
            chk("b2b_last", 64'(bus.chunk_last), 64'(i == 31));
            chk("b2b_add_rst", 64'(bus.add_rst), 64'd0);
            chk("b2b_c", 64'(sum[W-1:0]), 64'(i + 1));
            chk("b2b_ready", 64'(bus.in_ready), 64'(i != 31));
            if (i < 31) drive(1'b1, W'(i + 1), 32'd1);
            else drive(1'b0, '0, '0);
        end
        step();
        chk("clr_busy", 64'(bus.busy), 64'd1);
        chk("clr_add_rst", 64'(bus.add_rst), 64'd1);
        chk("clr_cv", 64'(bus.chunk_valid), 64'd0);
        chk("clr_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_add_rst", 64'(bus.add_rst), 64'd1);

        // bubble carry preservation
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i == 5) ? 32'hFFFF_FFFF : 32'd0, (i == 5) ? 32'd1 : 32'd0);
            step();
        end
        chk("bub_idx5", 64'(bus.chunk_idx), 64'd5);
        chk("bub_c5", 64'(sum[W-1:0]), 64'd0);
        drive(1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bub_a", 64'(bus.add_a), 64'hFFFF_FFFF);
            chk("bub_b", 64'(bus.add_b), 64'd0);
            chk("bub_cv", 64'(bus.chunk_valid), 64'd0);
            chk("bub_idx", 64'(bus.chunk_idx), 64'd5);
        end
        drive(1'b1, 32'd0, 32'd0);
        step();
        chk("bub_idx6", 64'(bus.chunk_idx), 64'd6);
        chk("bub_cv6", 64'(bus.chunk_valid), 64'd1);
        chk("bub_c6", 64'(sum[W-1:0]), 64'd1);
        for (int i = 7; i < 32; i++) step();
        chk("bub_last", 64'(bus.chunk_last), 64'd1);
        drive(1'b0, '0, '0);
        wait_idle();

        // full carry chain
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, (i == 0) ? 32'd1 : 32'd0);
            step();
            chk("chain_c", 64'(sum[W-1:0]), 64'd0);
        end
        chk("chain_carry_out", 64'(sum[W]), 64'd1);
        drive(1'b0, '0, '0);
        step();
        step();
        chk("chain_busy", 64'(bus.busy), 64'd0);
        chk("chain_carry_clr", 64'(carry), 64'd0);

        // async reset while presenting chunk 10
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, W'(i), 32'd0);
            step();
        end
        chk("ar_idx10", 64'(bus.chunk_idx), 64'd10);
        drive(1'b0, '0, '0);
        #1 rst = 1'b1;
        #1;
        chk("ar_add_rst", 64'(bus.add_rst), 64'd1);
        chk("ar_cv", 64'(bus.chunk_valid), 64'd0);
        chk("ar_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'd5, 32'd7);
        step();
        chk("ar_new_idx", 64'(bus.chunk_idx), 64'd0);
        chk("ar_new_cv", 64'(bus.chunk_valid), 64'd1);
        chk("ar_new_c", 64'(sum[W-1:0]), 64'd12);

        // abort while presenting chunk 7 with in_valid high
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, W'(i), 32'd0);
            step();
        end
        chk("ab_idx7", 64'(bus.chunk_idx), 64'd7);
        bus.abort = 1'b1;
        drive(1'b1, 32'd99, 32'd0);
        #1;
        chk("ab_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("ab_busy", 64'(bus.busy), 64'd1);
        chk("ab_add_rst", 64'(bus.add_rst), 64'd1);
        chk("ab_cv", 64'(bus.chunk_valid), 64'd0);
        chk("ab_idx_hold", 64'(bus.chunk_idx), 64'd7);
        bus.abort = 1'b0;
        drive(1'b0, '0, '0);
        chk("ab_clr_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("ab_idle_busy", 64'(bus.busy), 64'd0);
        chk("ab_idle_ready", 64'(bus.in_ready), 64'd1);

        // back-to-back operations with in_valid held high
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, (i == 31) ? 32'hFFFF_FFFF : W'(i), (i == 31) ? 32'd1 : 32'd0);
            step();
        end
        chk("bb_last", 64'(bus.chunk_last), 64'd1);
        chk("bb_c31", 64'(sum[W-1:0]), 64'd0);
        drive(1'b1, 32'd3, 32'd4);
        chk("bb_ready31", 64'(bus.in_ready), 64'd0);
        step();
        chk("bb_clr_ready", 64'(bus.in_ready), 64'd0);
        chk("bb_clr_cv", 64'(bus.chunk_valid), 64'd0);
        step();
        chk("bb_idle_ready", 64'(bus.in_ready), 64'd1);
        chk("bb_idle_cv", 64'(bus.chunk_valid), 64'd0);
        chk("bb_idle_busy", 64'(bus.busy), 64'd0);
        step();
        chk("bb_new_cv", 64'(bus.chunk_valid), 64'd1);
        chk("bb_new_idx", 64'(bus.chunk_idx), 64'd0);
        chk("bb_new_a", 64'(bus.add_a), 64'd3);
        chk("bb_new_c", 64'(sum[W-1:0]), 64'd7);
        drive(1'b0, '0, '0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        chk("bb_end_busy", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
